ram_stream_fifo: RTL
====================

# ram_stream_fifo

Synchronous FIFO with valid/ready streaming ports on both sides, built around a dual-port register array with synchronous write and asynchronous read. It is the initiator-side controller for that storage style: it generates write and read addresses, enables, and occupancy tracking. It sits between two streaming stages as a rate-decoupling buffer in first-word-fall-through (FWFT) mode, so the head word is always visible on `m_data`.

## Interface
- `DEPTH`, 64: number of entries; must be a power of two, at least 2.
- `DATA_WIDTH`, 8: word width in bits.
- `AFULL_LEVEL`, DEPTH-2: `almost_full` asserts when `count >= AFULL_LEVEL`; legal range 1..DEPTH.
- `AdrBits` (local): $clog2(DEPTH).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous clear of contents; same effect as `rst` on all state.
- `s_valid` in 1: upstream word present.
- `s_ready` out 1: FIFO accepts a word this cycle.
- `s_data` in DATA_WIDTH: upstream word.
- `m_valid` out 1: head word available.
- `m_ready` in 1: downstream consumes the head word this cycle.
- `m_data` out DATA_WIDTH: head word; zero when `m_valid` is 0.
- `count` out AdrBits+1: current occupancy, 0..DEPTH.
- `almost_full` out 1: `count >= AFULL_LEVEL`.

## Operation
- Storage: `DEPTH` x `DATA_WIDTH` array. Write is registered at `wr_ptr[AdrBits-1:0]`. Read is combinational from `rd_ptr[AdrBits-1:0]`.
- Pointers: `wr_ptr` and `rd_ptr` are each AdrBits+1 bits, and the MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `count` = `wr_ptr - rd_ptr`, modulo 2^(AdrBits+1).
- Push: `push = s_valid && s_ready`. It writes `s_data`, then `wr_ptr` increments by 1.
- Pop: `pop = m_valid && m_ready`. `rd_ptr` increments by 1.
- `s_ready` = !full && !rst && !flush. It depends only on registered state and the reset/flush inputs, never on `s_valid` or `m_ready`.
- `m_valid` = !empty. `m_data` = array[rd_ptr] when `m_valid`, else 0.
- Simultaneous push and pop:
  - Both pointers advance and `count` is unchanged.
  - When full, `s_ready` is 0, so a push is never accepted in the same cycle as a pop from full. No combinational pass-through.
  - When empty, no pop is possible, so there is no write-to-read bypass.
- Wrap-around: pointer low bits wrap from DEPTH-1 to 0 with the MSB toggling. Data order is preserved across the wrap.
- Reset or flush (either one, checked at the clock edge):
  - Both pointers return to 0.
  - Any push or pop in that cycle is discarded.
  - Array contents are not cleared.
- Protocol rules:
  - Upstream must hold `s_data` stable while `s_valid && !s_ready`.
  - Once `m_valid` is asserted it stays high until a pop, and `m_data` is stable until then.

## Timing
- Reset values, from the cycle after `rst` is sampled high:
  - `m_valid`=0, `m_data`=0, `count`=0, `almost_full`=0.
  - `s_ready`=1 once `rst` is low.
- Write-to-read latency: a word pushed at edge N appears on `m_data` with `m_valid`=1 after edge N (same cycle as the new `count`). That is one cycle of latency from push to visibility.
- Pop latency: zero. Data is consumed at the edge where `m_valid && m_ready`. The next word, or 0 if the FIFO becomes empty, is visible immediately after that edge.
- `count`, `almost_full`, `s_ready` and `m_valid` all reflect post-edge state. There is no combinational path from `s_valid` or `m_ready` to any output.
- `rst` or `flush` held for multiple cycles keeps the FIFO empty with `s_ready`=0 for the whole time.

## Test plan
Bench configuration: DEPTH=4, DATA_WIDTH=8, AFULL_LEVEL=3.

- **Reset:** assert `rst` for 2 cycles with `s_valid`=1 and `s_data`=0xAA.
  - Required: `s_ready`=0 during reset; afterwards `count`=0, `m_valid`=0, `m_data`=0x00.
  - Required: no word enters.
- **Fill to full:** push 0x11, 0x22, 0x33, 0x44 with `m_ready`=0.
  - Required: `almost_full` rises when `count`=3.
  - Required: after the 4th push, `count`=4 and `s_ready`=0.
  - Required: a 5th attempt with 0x55 is held off and not stored.
  - Required: `m_data` shows 0x11 throughout.
- **Drain and wrap:** from full, pop 2 words, push 0x55 and 0x66, then pop all.
  - Required: output order 0x11, 0x22, 0x33, 0x44, 0x55, 0x66.
  - Required: `count` ends at 0 and `m_data` ends at 0.
- **Simultaneous push and pop:** at `count`=2, hold `s_valid`=1 and `m_ready`=1 for 8 cycles with an incrementing 0x80..0x87.
  - Required: `count` stays at 2.
  - Required: outputs are the two prior words, then 0x80..0x85 in order.
- **Empty push latency:** from empty, push 0x5A at edge N.
  - Required: `m_valid`=0 before edge N, then `m_valid`=1 and `m_data`=0x5A after it.
  - Required: `m_ready`=1 with an empty FIFO does not change `rd_ptr`.
- **Flush mid-operation:** with `count`=3, assert `flush` together with `s_valid` and `m_ready` for 1 cycle.
  - Required: next cycle `count`=0, `m_valid`=0, `s_ready`=1.
  - Required: the flush-cycle push is discarded.
  - Required: a following push of 0x77 is read back as 0x77.

Source files
------------

// File: rtl/ram_stream_fifo_if.sv
// ---------------------------------------------------------------------------
// ram_stream_fifo_if
// Streaming handshake bundle for ram_stream_fifo.
//   s_valid / s_ready / s_data : upstream (write) side
//   m_valid / m_ready / m_data : downstream (read) side, head word in FWFT form
// Modports:
//   master : the environment; drives the upstream word and the downstream ready
//   slave  : the FIFO; drives s_ready and the head word
// ---------------------------------------------------------------------------
interface ram_stream_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/ram_stream_fifo.sv
// ---------------------------------------------------------------------------
// ram_stream_fifo
// First-word-fall-through FIFO around a register array with registered write
// and combinational read. Provides pointer generation, occupancy tracking and
// valid/ready handshakes on both sides.
// Ports:
//   clk         : single clock, rising edge
//   rst         : synchronous active-high reset (pointers only)
//   flush       : synchronous clear, same effect as rst
//   bus         : streaming handshake bundle (slave modport)
//   count       : occupancy 0..DEPTH
//   almost_full : count >= AFULL_LEVEL
// ---------------------------------------------------------------------------
module ram_stream_fifo #(
  parameter  int DEPTH       = 64,
  parameter  int DATA_WIDTH  = 8,
  parameter  int AFULL_LEVEL = DEPTH - 2,
  localparam int AdrBits     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  ram_stream_fifo_if.slave   bus,
  output logic [AdrBits:0]   count,
  output logic               almost_full
);

  // AFULL_LEVEL never exceeds DEPTH, so it fits in the count width.
  localparam logic [AdrBits:0] AfullThr = AFULL_LEVEL[AdrBits:0];
  localparam logic [AdrBits:0] PtrOne   = {{AdrBits{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AdrBits:0]      r_wr_ptr;
  logic [AdrBits:0]      r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_clear;
  logic w_push;
  logic w_pop;

  // Status flags, handshakes and head-word read from registered pointers.
  always_comb begin
    w_clear     = rst | flush;
    w_empty     = (r_wr_ptr == r_rd_ptr);
    // Same slot but opposite lap: every entry occupied.
    w_full      = (r_wr_ptr[AdrBits-1:0] == r_rd_ptr[AdrBits-1:0]) &&
                  (r_wr_ptr[AdrBits] != r_rd_ptr[AdrBits]);
    bus.s_ready = ~w_full & ~w_clear;
    bus.m_valid = ~w_empty;
    w_push      = bus.s_valid & bus.s_ready;
    w_pop       = bus.m_valid & bus.m_ready;
    // Wrap bit makes the modular difference the true occupancy.
    count       = r_wr_ptr - r_rd_ptr;
    almost_full = (count >= AfullThr);
    if (w_empty) begin
      bus.m_data = {DATA_WIDTH{1'b0}};
    end else begin
      bus.m_data = r_mem[r_rd_ptr[AdrBits-1:0]];
    end
  end

  // Storage write; contents survive reset and flush by design.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AdrBits-1:0]] <= bus.s_data;
    end
  end

  // Pointer update; clear wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= {(AdrBits+1){1'b0}};
      r_rd_ptr <= {(AdrBits+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
    end
  end

endmodule
